hall_speed_meter: RTL and testbench

Parametrised hall-sensor speed meter for the BLDC controller: samples the three hall lines, qualifies commutation events, and reports speed as either commutations per fixed window (count mode) or ticks between commutations (period mode). It also reports rotation direction and hall faults. Everything runs on the single system clock, using clock enables rather than derived clocks. It replaces the fixed-width, count-only speed path and feeds the rpm lookup and control loop.

---
 rtl/hall_speed_meter.sv | 187 ++++++++++++++++++
 tb/tb_hall_speed_meter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_speed_meter.sv
// hall_speed_meter: qualifies hall commutations and reports speed, direction and hall faults.
// Speed is either commutations per window (mode=0) or ticks between commutations (mode=1).
module hall_speed_meter #(
    parameter int DWIDTH   = 11,
    parameter int PRESCALE = 8192,
    parameter int WINDOW   = 435
) (
    input  logic              clock_sys,
    input  logic              reset,
    input  logic [2:0]        hall_effect,
    input  logic              mode,
    output logic [DWIDTH-1:0] speed,
    output logic              valid,
    output logic              direction,
    output logic              hall_fault
);

    localparam int PW = $clog2(PRESCALE);
    localparam int WW = $clog2(WINDOW);
    localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WW-1:0]     WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [DWIDTH-1:0] CNT_MAX    = {DWIDTH{1'b1}};

    // Forward rotation order is 001->011->010->110->100->101->001.
    function automatic logic [2:0] fwd_next(input logic [2:0] s);
        logic [2:0] n;
        case (s)
            3'b001:  n = 3'b011;
            3'b011:  n = 3'b010;
            3'b010:  n = 3'b110;
            3'b110:  n = 3'b100;
            3'b100:  n = 3'b101;
            3'b101:  n = 3'b001;
            default: n = 3'b000;
        endcase
        return n;
    endfunction

    function automatic logic is_legal(input logic [2:0] s);
        return (s != 3'b000) && (s != 3'b111);
    endfunction

    logic [2:0]        sync1_q, sync1_d;
    logic [2:0]        sync2_q, sync2_d;
    logic [2:0]        prev_q, prev_d;
    logic              mode_q, mode_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [WW-1:0]     win_q, win_d;
    logic [DWIDTH-1:0] edge_q, edge_d;
    logic [DWIDTH-1:0] period_q, period_d;
    logic              fault_q, fault_d;
    logic              armed_q, armed_d;
    logic [DWIDTH-1:0] speed_q, speed_d;
    logic              valid_q, valid_d;
    logic              direction_q, direction_d;
    logic              hall_fault_q, hall_fault_d;

    logic              sync_legal;
    logic              prev_legal;
    logic              hall_event;
    logic              step_fwd;
    logic              step_rev;
    logic              fault_now;
    logic              tick;
    logic [DWIDTH-1:0] edge_inc;

    // Synchronise the hall lines and classify each change as forward, reverse, skip or illegal.
    always_comb begin
        sync1_d     = hall_effect;
        sync2_d     = sync1_q;
        sync_legal  = is_legal(sync2_q);
        prev_legal  = is_legal(prev_q);
        hall_event  = sync_legal && prev_legal && (sync2_q != prev_q);
        step_fwd    = hall_event && (fwd_next(prev_q) == sync2_q);
        step_rev    = hall_event && (fwd_next(sync2_q) == prev_q);
        // The all-zero pipeline right after reset is not a sensor fault, so illegal
        // states only count once a legal state has been seen.
        fault_now   = (hall_event && !step_fwd && !step_rev) || (!sync_legal && prev_legal);
        prev_d      = sync_legal ? sync2_q : prev_q;
        direction_d = direction_q;
        if (step_fwd) begin
            direction_d = 1'b1;
        end else if (step_rev) begin
            direction_d = 1'b0;
        end
    end

    // Prescaler, window/edge counting, period measurement and result publication.
    always_comb begin
        tick         = (presc_q == PRESC_LAST);
        presc_d      = tick ? '0 : presc_q + PW'(1);
        mode_d       = mode;
        win_d        = win_q;
        edge_d       = edge_q;
        period_d     = period_q;
        fault_d      = fault_q | fault_now;
        armed_d      = armed_q;
        speed_d      = speed_q;
        valid_d      = 1'b0;
        hall_fault_d = hall_fault_q;
        edge_inc     = (hall_event && (edge_q != CNT_MAX)) ? edge_q + DWIDTH'(1) : edge_q;

        if (mode != mode_q) begin
            presc_d  = '0;
            win_d    = '0;
            edge_d   = '0;
            period_d = '0;
            fault_d  = 1'b0;
            armed_d  = 1'b0;
        end else if (!mode_q) begin
            edge_d = edge_inc;
            if (tick) begin
                if (win_q == WIN_LAST) begin
                    win_d        = '0;
                    speed_d      = edge_inc;
                    valid_d      = 1'b1;
                    hall_fault_d = fault_q | fault_now;
                    edge_d       = '0;
                    fault_d      = 1'b0;
                end else begin
                    win_d = win_q + WW'(1);
                end
            end
        end else begin
            if (hall_event) begin
                // The first event after entry only starts the interval being timed.
                if (armed_q) begin
                    speed_d      = period_q;
                    valid_d      = 1'b1;
                    hall_fault_d = fault_q | fault_now;
                end
                armed_d  = 1'b1;
                period_d = '0;
                fault_d  = 1'b0;
            end else if (tick && (period_q != CNT_MAX)) begin
                period_d = period_q + DWIDTH'(1);
                // Reaching saturation reports a stall once; the counter then sticks.
                if ((period_q == CNT_MAX - DWIDTH'(1)) && armed_q) begin
                    speed_d      = CNT_MAX;
                    valid_d      = 1'b1;
                    hall_fault_d = fault_q | fault_now;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock_sys or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            mode_q       <= 1'b0;
            presc_q      <= '0;
            win_q        <= '0;
            edge_q       <= '0;
            period_q     <= '0;
            fault_q      <= 1'b0;
            armed_q      <= 1'b0;
            speed_q      <= '0;
            valid_q      <= 1'b0;
            direction_q  <= 1'b1;
            hall_fault_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            mode_q       <= mode_d;
            presc_q      <= presc_d;
            win_q        <= win_d;
            edge_q       <= edge_d;
            period_q     <= period_d;
            fault_q      <= fault_d;
            armed_q      <= armed_d;
            speed_q      <= speed_d;
            valid_q      <= valid_d;
            direction_q  <= direction_d;
            hall_fault_q <= hall_fault_d;
        end
    end

    assign speed      = speed_q;
    assign valid      = valid_q;
    assign direction  = direction_q;
    assign hall_fault = hall_fault_q;

endmodule

// File: tb/tb_hall_speed_meter.sv
// tb_hall_speed_meter: directed and randomized hall motion checked against a behavioural model.
module tb_hall_speed_meter;

    localparam int DW   = 4;
    localparam int PS   = 4;
    localparam int WN   = 10;
    localparam int MAXV = (1 << DW) - 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    hall  = 3'b000;
    logic          mode  = 1'b0;
    logic [DW-1:0] speed;
    logic          valid;
    logic          direction;
    logic          hall_fault;

    logic [2:0] seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    int check_count = 0;
    int fail_count  = 0;
    int valid_count = 0;
    int last_speed  = 0;
    int last_fault  = 0;
    int pos         = 0;
    int step_phase  = 0;

    // Reference model state: rotor position index, delayed hall samples, elapsed counts.
    logic [2:0]    m_dly [2];
    int            m_prev_pos;
    int            m_cyc;
    int            m_ticks;
    int            m_edges;
    int            m_period;
    bit            m_fault;
    bit            m_armed;
    bit            m_mode;
    logic [DW-1:0] exp_speed;
    bit            exp_valid;
    bit            exp_dir;
    bit            exp_fault;

    hall_speed_meter #(.DWIDTH(DW), .PRESCALE(PS), .WINDOW(WN)) dut (
        .clock_sys  (clk),
        .reset      (rst_n),
        .hall_effect(hall),
        .mode       (mode),
        .speed      (speed),
        .valid      (valid),
        .direction  (direction),
        .hall_fault (hall_fault)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    function automatic int pos_of(input logic [2:0] s);
        int r = -1;
        for (int i = 0; i < 6; i++) if (seq[i] === s) r = i;
        return r;
    endfunction

    function automatic void model_reset();
        m_dly[0]   = 3'b000;
        m_dly[1]   = 3'b000;
        m_prev_pos = -1;
        m_cyc      = 0;
        m_ticks    = 0;
        m_edges    = 0;
        m_period   = 0;
        m_fault    = 0;
        m_armed    = 0;
        m_mode     = 0;
        exp_speed  = '0;
        exp_valid  = 0;
        exp_dir    = 1;
        exp_fault  = 0;
    endfunction

    function automatic void model_step();
        int  p    = pos_of(m_dly[1]);
        int  d;
        bit  ev   = 0;
        bit  fwd  = 0;
        bit  rev  = 0;
        bit  fnow = 0;
        bit  tick;
        if (p < 0) begin
            fnow = (m_prev_pos >= 0);
        end else if (m_prev_pos >= 0 && p != m_prev_pos) begin
            ev = 1;
            d  = (p - m_prev_pos + 6) % 6;
            if (d == 1) fwd = 1;
            else if (d == 5) rev = 1;
            else fnow = 1;
        end
        if (p >= 0) m_prev_pos = p;
        m_dly[1] = m_dly[0];
        m_dly[0] = hall;
        tick = ((m_cyc % PS) == PS - 1);
        m_cyc++;
        exp_valid = 0;
        if (fwd) exp_dir = 1;
        else if (rev) exp_dir = 0;
        if (mode != m_mode) begin
            m_cyc    = 0;
            m_ticks  = 0;
            m_edges  = 0;
            m_period = 0;
            m_fault  = 0;
            m_armed  = 0;
        end else if (!m_mode) begin
            if (ev && m_edges < MAXV) m_edges++;
            m_fault |= fnow;
            if (tick) begin
                m_ticks++;
                if (m_ticks == WN) begin
                    exp_speed = DW'(m_edges);
                    exp_fault = m_fault;
                    exp_valid = 1;
                    m_edges   = 0;
                    m_fault   = 0;
                    m_ticks   = 0;
                end
            end
        end else begin
            m_fault |= fnow;
            if (ev) begin
                if (m_armed) begin
                    exp_speed = DW'(m_period);
                    exp_fault = m_fault;
                    exp_valid = 1;
                end
                m_armed  = 1;
                m_period = 0;
                m_fault  = 0;
            end else if (tick && m_period < MAXV) begin
                m_period++;
                if (m_period == MAXV && m_armed) begin
                    exp_speed = DW'(MAXV);
                    exp_fault = m_fault;
                    exp_valid = 1;
                end
            end
        end
        m_mode = mode;
    endfunction

    // Advance the reference model on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        expect_eq({tag, "_speed"}, 32'(speed), 32'(exp_speed));
        expect_eq({tag, "_valid"}, 32'(valid), 32'(exp_valid));
        expect_eq({tag, "_dir"},   32'(direction), 32'(exp_dir));
        expect_eq({tag, "_fault"}, 32'(hall_fault), 32'(exp_fault));
        if (valid === 1'b1) begin
            valid_count++;
            last_speed = int'(speed);
            last_fault = int'(hall_fault);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] value);
        hall = value;
    endtask

    task automatic step(input int dir);
        pos = (pos + dir + 6) % 6;
        apply_stimulus(seq[pos]);
    endtask

    task automatic run_cycles(input int ncyc, input int every, input int dir,
                              input bit stop_on_valid, input string tag, output bit got);
        got = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            check_output(tag);
            if (stop_on_valid && valid === 1'b1) begin
                got = 1;
                return;
            end
            if (every > 0) begin
                step_phase++;
                if (step_phase >= every) begin
                    step_phase = 0;
                    step(dir);
                end
            end
        end
    endtask

    task automatic wait_valid(input int bound, input int every, input int dir, input string tag);
        bit got;
        run_cycles(bound, every, dir, 1, tag, got);
        expect_eq({tag, "_timeout"}, 32'(got), 32'd1);
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i <= ncyc; i++) begin
            if (i > 0) @(negedge clk);
            expect_eq("rst_speed", 32'(speed), 32'd0);
            expect_eq("rst_valid", 32'(valid), 32'd0);
            expect_eq("rst_dir",   32'(direction), 32'd1);
            expect_eq("rst_fault", 32'(hall_fault), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed scenarios followed by a randomized run, all checked every cycle.
    initial begin
        bit got;
        int vc0;
        int r;
        model_reset();
        repeat (2) @(negedge clk);
        check_output("reset");
        expect_eq("reset_dir_const", 32'(direction), 32'd1);
        rst_n = 1'b1;
        apply_stimulus(seq[0]);

        $display("[TB] count mode forward");
        vc0 = valid_count;
        step_phase = 0;
        run_cycles(130, 8, 1, 0, "cnt_fwd", got);
        expect_eq("cnt_fwd_nvalid", 32'(valid_count - vc0), 32'd3);
        expect_eq("cnt_fwd_speed5", 32'(last_speed), 32'd5);
        expect_eq("cnt_fwd_dir1", 32'(direction), 32'd1);
        expect_eq("cnt_fwd_clean", 32'(last_fault), 32'd0);

        $display("[TB] count mode reverse");
        run_cycles(130, 8, -1, 0, "cnt_rev", got);
        expect_eq("cnt_rev_speed5", 32'(last_speed), 32'd5);
        expect_eq("cnt_rev_dir0", 32'(direction), 32'd0);

        $display("[TB] illegal state and skip");
        wait_valid(60, 8, 1, "flt_align");
        apply_stimulus(3'b000);
        run_cycles(8, 0, 1, 0, "flt_zero", got);
        step(1);
        run_cycles(8, 0, 1, 0, "flt_resume", got);
        step(2);
        step_phase = 0;
        wait_valid(60, 8, 1, "flt_win");
        expect_eq("flt_reported", 32'(last_fault), 32'd1);
        wait_valid(60, 8, 1, "flt_clean");
        expect_eq("flt_cleared", 32'(last_fault), 32'd0);

        $display("[TB] period mode");
        mode = 1'b1;
        step_phase = 0;
        run_cycles(150, 12, 1, 0, "per", got);
        expect_eq("per_speed3", 32'(last_speed), 32'd3);

        $display("[TB] period stall");
        wait_valid(30, 12, 1, "stall_align");
        vc0 = valid_count;
        run_cycles(100, 0, 1, 0, "stall", got);
        expect_eq("stall_once", 32'(valid_count - vc0), 32'd1);
        expect_eq("stall_speed", 32'(last_speed), 32'(MAXV));
        step(1);
        run_cycles(10, 0, 1, 0, "stall_evt", got);
        expect_eq("stall_evt_count", 32'(valid_count - vc0), 32'd2);
        expect_eq("stall_evt_speed", 32'(last_speed), 32'(MAXV));

        $display("[TB] mode toggle mid-window");
        mode = 1'b0;
        step_phase = 0;
        vc0 = valid_count;
        run_cycles(20, 8, 1, 0, "tog_a", got);
        mode = 1'b1;
        run_cycles(3, 8, 1, 0, "tog_b", got);
        mode = 1'b0;
        run_cycles(35, 8, 1, 0, "tog_c", got);
        expect_eq("tog_partial", 32'(valid_count - vc0), 32'd0);
        run_cycles(100, 8, 1, 0, "tog_full", got);
        expect_eq("tog_speed5", 32'(last_speed), 32'd5);

        $display("[TB] reset mid-window");
        wait_valid(60, 8, 1, "rst_align");
        run_cycles(15, 8, 1, 0, "rst_pre", got);
        do_reset(3);
        vc0 = valid_count;
        step_phase = 0;
        run_cycles(38, 8, 1, 0, "rst_post", got);
        expect_eq("rst_no_valid", 32'(valid_count - vc0), 32'd0);
        run_cycles(100, 8, 1, 0, "rst_full", got);
        expect_eq("rst_speed5", 32'(last_speed), 32'd5);

        $display("[TB] edge saturation");
        step_phase = 0;
        run_cycles(130, 2, 1, 0, "sat", got);
        expect_eq("sat_speed", 32'(last_speed), 32'(MAXV));

        $display("[TB] randomized motion");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            check_output("rand");
            r = int'($urandom_range(0, 999));
            if (r < 120) step(1);
            else if (r < 170) step(-1);
            else if (r < 185) step(int'($urandom_range(2, 3)));
            else if (r < 192) apply_stimulus(($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111);
            else if (r < 196) mode = ~mode;
            else if (r == 196 && i > 100) begin
                do_reset(2);
                check_output("rand_rst");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
